// File: rtl/dlbf_rxram_sched_if.sv
// dlbf_rxram_sched_if: groups the three buses around the receive-RAM scheduler:
// the host CSR/BRAM bridge access, the inbound AXI4-Stream and the RAM port B.
// The slave modport is the scheduler's view; master is the surrounding system.
`timescale 1ns/1ps
interface dlbf_rxram_sched_if;
  // host bridge
  logic        host_en;
  logic [7:0]  host_we;
  logic [15:0] host_addr;
  logic [63:0] host_din;
  logic [63:0] host_dout;
  // capture stream
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  // receive-RAM port B
  logic        ram_en;
  logic [7:0]  ram_we;
  logic [15:0] ram_addr;
  logic [63:0] ram_din;
  logic [63:0] ram_dout;

  modport slave (
    input  host_en, host_we, host_addr, host_din,
    output host_dout,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output ram_en, ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output host_en, host_we, host_addr, host_din,
    input  host_dout,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  ram_en, ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/dlbf_rxram_sched.sv
// dlbf_rxram_sched: arbitrates receive-RAM port B between the host bridge
// (always wins) and the beamformer result stream, writes stream words
// sequentially, counts words and frames, and flags completion or overflow.
// Optional build macro RXRAM_WRAP_EN: write pointer wraps instead of stopping
// at the top of the RAM; FULL/ovf are never produced.
`timescale 1ns/1ps
module dlbf_rxram_sched #(
  parameter int ADDR_W = 13
) (
  input  logic                 BRAM_PORTA_clk,
  input  logic                 BRAM_PORTA_rst,
  input  logic                 slave_rst,
  input  logic [11:0]          niter,
  dlbf_rxram_sched_if.slave    bus,
  output logic                 rxdone,
  output logic                 ovf,
  output logic [15:0]          rxram_counter,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CAPTURE = 4'd1,
    DONE    = 4'd2,
    FULL    = 4'd3
  } state_t;

  // Host addresses are folded onto the implemented RAM depth.
  localparam logic [16:0] CAPACITY  = 17'd1 << ADDR_W;
  localparam logic [15:0] ADDR_MASK = CAPACITY[15:0] - 16'd1;

  state_t              state_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [11:0]         niter_q;
  logic [11:0]         frame_cnt_reg;
  logic [15:0]         count_reg;
  logic                ovf_reg;

  logic                ram_en_reg;
  logic [7:0]          ram_we_reg;
  logic [15:0]         ram_addr_reg;
  logic [63:0]         ram_din_reg;

  logic                rst_any;
  logic                tready;
  logic                accept;
  logic                last_frame;
  logic                full_hit;

  assign rst_any    = BRAM_PORTA_rst | slave_rst;
  // The stream only gets the port in cycles the host leaves free.
  assign tready     = (state_reg == CAPTURE) & ~bus.host_en & ~rst_any;
  assign accept     = bus.s_axis_tvalid & tready;
  assign last_frame = bus.s_axis_tlast & ((frame_cnt_reg + 12'd1) == niter_q);

`ifdef RXRAM_WRAP_EN
  // Pointer rolls over to 0 on its own; the top address is not special.
  assign full_hit = 1'b0;
`else
  assign full_hit = &wr_ptr_reg;
`endif

  // Scheduler FSM, write pointer, frame and word counters.
  always_ff @(posedge BRAM_PORTA_clk) begin
    if (rst_any) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      niter_q       <= '0;
      frame_cnt_reg <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (niter != 12'd0) begin
            state_reg     <= CAPTURE;
            niter_q       <= niter;
            frame_cnt_reg <= '0;
          end
        end
        CAPTURE: begin
          if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            // Saturate rather than roll back to 0 so a long wrapping capture
            // never reports a misleadingly small word count.
            if (count_reg != 16'hFFFF)
              count_reg <= count_reg + 16'd1;
            if (bus.s_axis_tlast)
              frame_cnt_reg <= frame_cnt_reg + 12'd1;
            // Completing the last frame takes precedence over running out of RAM.
            if (last_frame)
              state_reg <= DONE;
            else if (full_hit) begin
              state_reg <= FULL;
              ovf_reg   <= 1'b1;
            end
          end
        end
        default: ; // DONE and FULL are left only through reset
      endcase
    end
  end

  // Registered port-B drive: host first, then an accepted stream beat.
  always_ff @(posedge BRAM_PORTA_clk) begin
    if (bus.host_en) begin
      ram_en_reg   <= 1'b1;
      ram_we_reg   <= bus.host_we;
      ram_addr_reg <= bus.host_addr & ADDR_MASK;
      ram_din_reg  <= bus.host_din;
    end else if (BRAM_PORTA_rst) begin
      ram_en_reg   <= 1'b0;
      ram_we_reg   <= '0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
    end else if (accept) begin
      ram_en_reg   <= 1'b1;
      ram_we_reg   <= 8'hFF;
      ram_addr_reg <= 16'(wr_ptr_reg);
      ram_din_reg  <= bus.s_axis_tdata;
    end else begin
      ram_en_reg   <= 1'b0;
      ram_we_reg   <= '0;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.host_dout     = bus.ram_dout;
  assign bus.ram_en        = ram_en_reg;
  assign bus.ram_we        = ram_we_reg;
  assign bus.ram_addr      = ram_addr_reg;
  assign bus.ram_din       = ram_din_reg;

  assign rxdone        = (state_reg == DONE);
  assign ovf           = ovf_reg;
  assign rxram_counter = count_reg;
  assign state         = state_reg;

endmodule
